dff_share_arbiter: RTL and testbench
====================================

// Module: dff_share_arbiter
// PURPOSE
//  Round-robin write arbiter for one shared WIDTH-bit D-flip-flop register.
//  NUM_REQ requesters each present data with a request. One winner per grant cycle loads the register.
//  Sits between client blocks and the shared state flop; q/q_valid fan out to all readers.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WIDTH    8  register/data width
// PORTS
//  clk      in   1                  single clock, rising edge
//  reset    in   1                  synchronous, active-high
//  req      in   NUM_REQ            per-requester write request, level
//  wdata    in   NUM_REQ*WIDTH      packed data; slice i belongs to req[i]
//  gnt      out  NUM_REQ            registered one-hot grant, 1-cycle pulse
//  owner    out  $clog2(NUM_REQ)    index of last granted requester
//  q        out  WIDTH              shared register contents
//  q_valid  out  1                  1 once any write has completed since reset
//  busy     out  1                  1 while state != IDLE
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. On reset: gnt=0, owner=0, q=0, q_valid=0, busy=0, state=IDLE, rr pointer=0 (req[0] highest priority).
//  - States: IDLE, GRANT (plus LOCKED with DFF_ARB_LOCK_EN).
//  - IDLE:
//    - if |req at edge: winner = first set bit at or after ptr, wrapping at NUM_REQ-1 -> 0.
//    - next cycle: state=GRANT, gnt[winner]=1, owner=winner.
//  - GRANT cycle:
//    - at its closing edge: q <= wdata[winner], q_valid <= 1, ptr <= (winner+1) mod NUM_REQ.
//    - Arbitration in this cycle masks req[owner]; requester must drop req the cycle after gnt.
//    - Other pending req -> GRANT again back-to-back (gnt moves to new one-hot); else IDLE.
//  - Latency: req rising at edge N -> gnt high cycle N+1 -> q updated after edge N+2.
//  - Throughput: 1 write/cycle when >=2 requesters alternate; a single requester gets 1 write per 2 cycles.
//  - req withdrawn before grant: no grant, no write; wdata sampled only on the grant edge.
//  - All req equal: strict rotation 0,1,2,...,NUM_REQ-1,0. No starvation: a pending req is granted within NUM_REQ grants.
//  - reset mid-GRANT: write aborted, q=0, everything to reset values on that edge.
//  - gnt is never multi-hot; gnt=0 in IDLE.
// CONFIGURATION
//  - Macro DFF_ARB_LOCK_EN adds input lock (NUM_REQ bits) and state LOCKED.
//  - With it:
//    - In GRANT, if lock[owner]=1, next state=LOCKED and ptr is frozen.
//    - In LOCKED only req[owner] is honoured: owner req -> GRANT to owner; others are held pending.
//    - lock[owner]=0 -> IDLE with normal rotation from ptr.
//    - reset clears the lock.
//  - Without it: no lock port, no LOCKED state; behaviour exactly as above.
// STRUCTURE
//  - Package dff_arb_pkg:
//    - state enum (IDLE, GRANT, LOCKED)
//    - function idx_w(n) = max(1,$clog2(n))
//    - localparam RESET_Q='0
//  - Sub-module rr_pick: combinational; inputs req_masked and ptr; outputs found and idx (first set bit at/after ptr, wrapping).
//  - Top holds FSM, ptr, gnt/owner regs, and the q/q_valid register.
// TESTING
//  - Reset: hold reset 2 cycles with req=4'hF -> gnt=0, q=0, q_valid=0, busy=0.
//  - Single write: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 next cycle, then q=8'hA5, q_valid=1, owner=2.
//  - Fairness: req=4'hF held (each requester drops for 1 cycle after its gnt, then re-asserts) -> gnt order 1,2,4,8,1,...; no one-hot violation.
//  - Back-to-back: req[0], req[3] together from IDLE -> gnt 0001 then 1000 on consecutive cycles; q ends at wdata[3].
//  - Reset mid-op: reset asserted during GRANT of req[1] (wdata=8'h3C) -> q stays 0, gnt=0 next cycle.
//  - LOCK_EN build: owner 2 grants with lock[2]=1 while req[0] is pending -> req[0] not granted until lock[2]=0; then granted from IDLE.

Source files
------------

// File: rtl/dff_share_arbiter_pkg.sv
// Shared definitions for the dff_share_arbiter block.
//   state_e  : arbiter FSM states (LOCKED is reachable only with DFF_ARB_LOCK_EN)
//   idx_w()  : width of a requester index, never less than one bit
//   RESET_Q  : fill value loaded into the shared register on reset
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic RESET_Q = 1'b0;

    function automatic int idx_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
//   req     : per-requester write request (level)
//   wdata   : packed write data, slice i belongs to req[i]
//   lock    : per-requester lock hold (only with DFF_ARB_LOCK_EN)
//   gnt     : registered one-hot grant pulse
//   owner   : index of the last granted requester
//   q       : shared register contents
//   q_valid : set once any write has completed since reset
//   busy    : arbiter is not idle
// Modports: master = client side, slave = arbiter side.
interface dff_share_arbiter_if
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
`ifdef DFF_ARB_LOCK_EN
    logic [NUM_REQ-1:0]       lock;
`endif
    logic [NUM_REQ-1:0]       gnt;
    logic [IW-1:0]            owner;
    logic [WIDTH-1:0]         q;
    logic                     q_valid;
    logic                     busy;

    modport master (
        output req, wdata,
`ifdef DFF_ARB_LOCK_EN
        output lock,
`endif
        input  gnt, owner, q, q_valid, busy
    );

    modport slave (
        input  req, wdata,
`ifdef DFF_ARB_LOCK_EN
        input  lock,
`endif
        output gnt, owner, q, q_valid, busy
    );

endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_masked : candidate requests
//   ptr        : highest-priority index this round
//   found      : at least one candidate is set
//   idx        : first set bit at or after ptr, wrapping past NUM_REQ-1 to 0
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_masked,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    logic          any_set;
    logic          hi_set;
    logic [IW-1:0] any_idx;
    logic [IW-1:0] hi_idx;

    // Two scans in one loop: the lowest set bit at/after ptr wins; if there is
    // none, the request wrapped around and the lowest set bit overall wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned and no latch is inferred.
        any_set = 1'b0;
        hi_set  = 1'b0;
        any_idx = '0;
        hi_idx  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_masked[j]) begin
                any_set = 1'b1;
                any_idx = IW'(j);
                if (IW'(j) >= ptr) begin
                    hi_set = 1'b1;
                    hi_idx = IW'(j);
                end
            end
        end
    end

    assign found = any_set;
    assign idx   = hi_set ? hi_idx : any_idx;

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
// One requester wins per grant cycle; its data is loaded at the closing edge
// of that cycle and q/q_valid fan out to every reader.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dff_share_arbiter_if.slave (req, wdata, [lock], gnt, owner, q, q_valid, busy)
// Optional feature: define DFF_ARB_LOCK_EN to add the lock input and the
// LOCKED state, which lets the current owner keep the register to itself.
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    dff_share_arbiter_if.slave  bus
);

    localparam int            IW   = idx_w(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    state_e             state;
    state_e             state_n;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      owner_inc;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   q;
    logic               q_valid;
    logic [WIDTH-1:0]   wsel;
    logic               hold_lock;
    logic               load_q;
    logic               busy;

    logic [NUM_REQ-1:0] pick_req;
    logic [IW-1:0]      pick_ptr;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;

    assign owner_inc = (owner == LAST) ? '0 : owner + IW'(1);
    assign owner_oh  = NUM_REQ'(1) << owner;

`ifdef DFF_ARB_LOCK_EN
    assign hold_lock = bus.lock[owner];
`else
    assign hold_lock = 1'b0;
`endif

    // Picker inputs per state. In GRANT the current owner is masked and the
    // search starts just past it; in LOCKED only the owner is a candidate.
    always_comb begin
        pick_req = bus.req;
        pick_ptr = ptr;
        if (state == GRANT) begin
            pick_req = bus.req & ~owner_oh;
            pick_ptr = owner_inc;
        end
`ifdef DFF_ARB_LOCK_EN
        else if (state == LOCKED) begin
            pick_req = bus.req & owner_oh;
            pick_ptr = owner;
        end
`endif
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_masked (pick_req),
        .ptr        (pick_ptr),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = pick_found ? GRANT : IDLE;
            GRANT: begin
                if (hold_lock)       state_n = LOCKED;
                else if (pick_found) state_n = GRANT;
                else                 state_n = IDLE;
            end
`ifdef DFF_ARB_LOCK_EN
            LOCKED: begin
                if (!hold_lock)      state_n = IDLE;
                else if (pick_found) state_n = GRANT;
                else                 state_n = LOCKED;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy   = (state != IDLE);
        load_q = (state == GRANT);
    end

    // Owner's data slice, selected with constant part-selects.
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) wsel = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    // Grant/owner registers, rotation pointer and the shared register.
    // A reset during GRANT wins over the pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            q       <= {WIDTH{RESET_Q}};
            q_valid <= 1'b0;
        end else begin
            gnt <= (state_n == GRANT) ? (NUM_REQ'(1) << pick_idx) : '0;
            if (state_n == GRANT) owner <= pick_idx;
            if (load_q) begin
                q       <= wsel;
                q_valid <= 1'b1;
                // A locking owner keeps the pointer frozen so normal rotation
                // resumes from where it stood once the lock is released.
                if (!hold_lock) ptr <= owner_inc;
            end
        end
    end

    assign bus.gnt     = gnt;
    assign bus.owner   = owner;
    assign bus.q       = q;
    assign bus.q_valid = q_valid;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: a cycle model built from the
// arbitration rules (who is granted, what gets written) is compared against
// the DUT on every falling edge, and directed scenarios add literal checks.
module tb_dff_share_arbiter;
    import dff_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dff_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    dff_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cur   = -1;   // requester granted in the current cycle, -1 if none
    int          m_ptr   = 0;    // highest-priority requester for the next fresh pick
    int          m_owner = 0;
    logic [W-1:0] m_q    = '0;
    bit          m_qv    = 1'b0;
    bit          m_locked = 1'b0;
    bit          m_valid = 1'b0;

    function automatic logic [W-1:0] slice(input logic [N*W-1:0] v, input int i);
        return W'(v >> (i * W));
    endfunction

    function automatic int first_from(input logic [N-1:0] bits, input int start);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (start + i) % N;
            if (((bits >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] r;
        int  nxt;
        bit  to_lock;
        r       = bus.req;
        nxt     = -1;
        to_lock = 1'b0;
        if (reset) begin
            m_cur = -1; m_ptr = 0; m_owner = 0; m_q = '0; m_qv = 1'b0;
            m_locked = 1'b0; m_valid = 1'b1;
        end else begin
            if (m_cur >= 0) begin
                m_q  = slice(bus.wdata, m_cur);
                m_qv = 1'b1;
`ifdef DFF_ARB_LOCK_EN
                to_lock = ((bus.lock >> m_cur) & N'(1)) != '0;
`endif
                if (!to_lock) begin
                    m_ptr = (m_cur + 1) % N;
                    r     = r & ~(N'(1) << m_cur);
                    nxt   = first_from(r, m_ptr);
                end
            end else if (m_locked) begin
`ifdef DFF_ARB_LOCK_EN
                if (((bus.lock >> m_owner) & N'(1)) == '0) m_locked = 1'b0;
                else if (((r >> m_owner) & N'(1)) != '0)   nxt = m_owner;
`endif
            end else begin
                nxt = first_from(r, m_ptr);
            end
            if (to_lock)       m_locked = 1'b1;
            else if (nxt >= 0) m_locked = 1'b0;
            m_cur = nxt;
            if (nxt >= 0) m_owner = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt",     32'(bus.gnt),     (m_cur >= 0) ? 32'(N'(1) << m_cur) : 32'd0);
            check("owner",   32'(bus.owner),   32'(m_owner));
            check("q",       32'(bus.q),       32'(m_q));
            check("q_valid", 32'(bus.q_valid), 32'(m_qv));
            check("busy",    32'(bus.busy),    32'((m_cur >= 0) || m_locked));
            check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] exp_rot [8];
        logic [N-1:0] prev;
        logic [N-1:0] pats [8];
        int           ngnt;

        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        pats    = '{4'b0110, 4'b1010, 4'b1111, 4'b0011, 4'b1000, 4'b0101, 4'b0000, 4'b1110};

        reset     = 1'b1;
        bus.req   = '1;
        bus.wdata = 32'hDEAD_BEEF;
`ifdef DFF_ARB_LOCK_EN
        bus.lock  = '0;
`endif
        // Reset held two cycles with every request raised.
        tick(); tick();
        check("rst_gnt",  32'(bus.gnt), 32'd0);
        check("rst_q",    32'(bus.q), 32'd0);
        check("rst_qv",   32'(bus.q_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset   = 1'b0;
        bus.req = '0;
        tick();

        // Single write from requester 2.
        bus.req   = 4'b0100;
        bus.wdata = {8'h11, 8'hA5, 8'h33, 8'h44};
        tick();
        check("sw_gnt",   32'(bus.gnt), 32'h4);
        check("sw_owner", 32'(bus.owner), 32'd2);
        check("sw_q_pre", 32'(bus.q), 32'd0);
        bus.req = '0;
        tick();
        check("sw_q",     32'(bus.q), 32'hA5);
        check("sw_qv",    32'(bus.q_valid), 32'd1);
        check("sw_idle",  32'(bus.gnt), 32'd0);

        // Fairness: all requesting, each drops for one cycle after its grant.
        do_reset();
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            bus.req   = ~prev;
            bus.wdata = 32'h4030_2010 + {4{8'(k)}};
            tick();
            check("rot_gnt", 32'(bus.gnt), 32'(exp_rot[k]));
            prev = bus.gnt;
        end
        bus.req = '0;
        tick(); tick();

        // Back-to-back grants for requesters 0 and 3.
        do_reset();
        bus.req   = 4'b1001;
        bus.wdata = {8'h33, 8'h22, 8'h21, 8'h11};
        tick();
        check("b2b_gnt0", 32'(bus.gnt), 32'h1);
        bus.req = 4'b1000;
        tick();
        check("b2b_gnt3", 32'(bus.gnt), 32'h8);
        check("b2b_q0",   32'(bus.q), 32'h11);
        bus.req = '0;
        tick();
        check("b2b_q3",   32'(bus.q), 32'h33);

        // Reset while requester 1 is in its grant cycle.
        bus.req   = 4'b0010;
        bus.wdata = 32'h0000_3C00;
        tick();
        check("rmid_gnt", 32'(bus.gnt), 32'h2);
        reset   = 1'b1;
        bus.req = '0;
        tick();
        check("rmid_q",   32'(bus.q), 32'd0);
        check("rmid_gnt0", 32'(bus.gnt), 32'd0);
        check("rmid_qv",  32'(bus.q_valid), 32'd0);
        reset = 1'b0;
        tick();

        // A lone requester holding req gets one write every two cycles.
        bus.req   = 4'b0001;
        bus.wdata = 32'h0000_00C3;
        ngnt      = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.gnt != '0) ngnt++;
        end
        check("solo_count", 32'(ngnt), 32'd3);
        bus.req = '0;
        tick();
        check("solo_q", 32'(bus.q), 32'hC3);

        // Mixed request patterns, checked by the model.
        for (int k = 0; k < 8; k++) begin
            bus.req   = pats[k];
            bus.wdata = 32'h9080_7060 ^ {4{8'(k * 17)}};
            tick(); tick();
        end
        bus.req = '0;
        tick(); tick();

`ifdef DFF_ARB_LOCK_EN
        // Requester 2 locks the register while requester 0 waits.
        do_reset();
        bus.req   = 4'b0100;
        bus.lock  = 4'b0100;
        bus.wdata = 32'h0077_0055;
        tick();
        check("lk_gnt2", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0001;
        tick();
        check("lk_q", 32'(bus.q), 32'h77);
        for (int k = 0; k < 3; k++) begin
            check("lk_hold", 32'(bus.gnt), 32'd0);
            tick();
        end
        bus.lock = '0;
        tick();
        check("lk_release", 32'(bus.gnt), 32'd0);
        tick();
        check("lk_gnt0", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        tick(); tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
